// File: rtl/equal_prec_counter_if.sv
// Result handshake bundle between the equal-precision counter and the
// frequency-compute stage: valid/ready plus the latched measurement.
interface equal_prec_counter_if #(
   parameter int CNT_W = 32
);
   logic             valid;
   logic             ready;
   logic [CNT_W-1:0] nb_out;
   logic [CNT_W-1:0] nx_out;
   logic             ovf;
   logic             busy;

   // Counter side drives the result, consumer side drives ready.
   modport master (
      output valid,
      output nb_out,
      output nx_out,
      output ovf,
      output busy,
      input  ready
   );

   modport slave (
      input  valid,
      input  nb_out,
      input  nx_out,
      input  ovf,
      input  busy,
      output ready
   );
endinterface

// File: rtl/equal_prec_counter.sv
// Equal-precision counter for the digital frequency meter.
// While the real gate is open it counts reference-clock cycles (nb) and D_in
// rising edges (nx); on gate close both counts are latched and offered on a
// valid/ready handshake. Fx = Fclk * nx / nb. Counters saturate, never wrap.
module equal_prec_counter #(
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_d_in,
   input  logic                 i_realgate,
   equal_prec_counter_if.master res_if
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   // Saturating increment: returns {saturated, value}; an all-ones input
   // with inc set stays all-ones and flags saturation.
   function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a,
                                              input logic             inc);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {{CNT_W{1'b0}}, inc};
      if (sum[CNT_W]) begin
         sat_add = {1'b1, {CNT_W{1'b1}}};
      end else begin
         sat_add = sum;
      end
   endfunction

   // Synchronizer and edge-detect registers; both inputs get the same
   // 3-stage path so a gate edge and its D_in edge land in the same cycle.
   logic r_d_meta, r_d_sync, r_d_dly;
   logic r_g_meta, r_g_sync, r_g_dly;

   logic w_dx_pulse;
   logic w_g_rise;
   logic w_g_fall;

   state_t r_state;
   state_t w_state_nxt;

   logic [CNT_W-1:0] r_nb, r_nx, r_nb_out, r_nx_out;
   logic             r_ovf_int, r_ovf, r_valid, r_busy;

   logic [CNT_W-1:0] w_nb_nxt, w_nx_nxt, w_nb_out_nxt, w_nx_out_nxt;
   logic             w_ovf_int_nxt, w_ovf_nxt, w_valid_nxt, w_busy_nxt;

   logic [CNT_W:0]   w_nb_inc;
   logic [CNT_W:0]   w_nx_inc;

   assign w_dx_pulse = r_d_sync & ~r_d_dly;
   assign w_g_rise   = r_g_sync & ~r_g_dly;
   assign w_g_fall   = ~r_g_sync & r_g_dly;

   assign w_nb_inc = sat_add(r_nb, 1'b1);
   assign w_nx_inc = sat_add(r_nx, w_dx_pulse);

   // Bring D_in and the real gate into the clk domain and keep one delayed copy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d_meta <= 1'b0;
         r_d_sync <= 1'b0;
         r_d_dly  <= 1'b0;
         r_g_meta <= 1'b0;
         r_g_sync <= 1'b0;
         r_g_dly  <= 1'b0;
      end else begin
         r_d_meta <= i_d_in;
         r_d_sync <= r_d_meta;
         r_d_dly  <= r_d_sync;
         r_g_meta <= i_realgate;
         r_g_sync <= r_g_meta;
         r_g_dly  <= r_g_sync;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decision; gate rises seen while holding a result are dropped.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_g_rise) begin
               w_state_nxt = ST_COUNT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_COUNT: begin
            if (w_g_fall) begin
               w_state_nxt = ST_HOLD;
            end else begin
               w_state_nxt = ST_COUNT;
            end
         end
         ST_HOLD: begin
            if (res_if.ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Counter and result next values for each state.
   always_comb begin
      w_nb_nxt      = r_nb;
      w_nx_nxt      = r_nx;
      w_ovf_int_nxt = r_ovf_int;
      w_nb_out_nxt  = r_nb_out;
      w_nx_out_nxt  = r_nx_out;
      w_ovf_nxt     = r_ovf;
      w_valid_nxt   = r_valid;
      case (r_state)
         ST_IDLE: begin
            if (w_g_rise) begin
               // The gate-open cycle is the first counted clock; the D_in
               // edge that opened the gate is not a whole period.
               w_nb_nxt      = CNT_ONE;
               w_nx_nxt      = CNT_ZERO;
               w_ovf_int_nxt = 1'b0;
            end else begin
               w_valid_nxt   = 1'b0;
            end
         end
         ST_COUNT: begin
            if (w_g_fall) begin
               // Closing edge completes the last period; nb is not bumped.
               w_nb_out_nxt = r_nb;
               w_nx_out_nxt = w_nx_inc[CNT_W-1:0];
               w_ovf_nxt    = r_ovf_int | w_nx_inc[CNT_W];
               w_valid_nxt  = 1'b1;
            end else if (r_g_sync) begin
               w_nb_nxt      = w_nb_inc[CNT_W-1:0];
               w_nx_nxt      = w_nx_inc[CNT_W-1:0];
               w_ovf_int_nxt = r_ovf_int | w_nb_inc[CNT_W] | w_nx_inc[CNT_W];
            end else begin
               w_valid_nxt   = 1'b0;
            end
         end
         ST_HOLD: begin
            if (res_if.ready) begin
               w_valid_nxt = 1'b0;
            end else begin
               w_valid_nxt = 1'b1;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
         end
      endcase
      w_busy_nxt = (w_state_nxt == ST_COUNT);
   end

   // Counters and registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nb      <= CNT_ZERO;
         r_nx      <= CNT_ZERO;
         r_ovf_int <= 1'b0;
         r_nb_out  <= CNT_ZERO;
         r_nx_out  <= CNT_ZERO;
         r_ovf     <= 1'b0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_nb      <= w_nb_nxt;
         r_nx      <= w_nx_nxt;
         r_ovf_int <= w_ovf_int_nxt;
         r_nb_out  <= w_nb_out_nxt;
         r_nx_out  <= w_nx_out_nxt;
         r_ovf     <= w_ovf_nxt;
         r_valid   <= w_valid_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   assign res_if.valid  = r_valid;
   assign res_if.nb_out = r_nb_out;
   assign res_if.nx_out = r_nx_out;
   assign res_if.ovf    = r_ovf;
   assign res_if.busy   = r_busy;

endmodule
